vec_strided_lsu: RTL and testbench
==================================

Name: vec_strided_lsu

Overview:
Strided load/store engine for the vector coprocessor; it is the initiator side of the native valid/ready memory interface. It accepts one command containing base, stride, vl and SEW. For a load it issues one memory read per element and streams the elements to the register-file writer. For a store it consumes an element stream and issues one byte-lane-masked write per element. It sits between the vector decode/execute unit and the shared memory port.

Parameters:
VL_W, 8, width of vl and element index (max vl = 2^VL_W-1)
ADDR_W, 32, byte address width

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  high only in IDLE
cmd_store  input  1  1=store, 0=load
cmd_base  input  ADDR_W  byte address of element 0
cmd_stride  input  32  signed byte stride
cmd_vl  input  VL_W  element count
cmd_sew  input  2  0=8b, 1=16b, 2=32b, 3=illegal
ld_valid  output  1  one-cycle pulse, loaded element valid
ld_data  output  32  zero-extended element
ld_idx  output  VL_W  element index
st_valid  input  1  store element offered
st_ready  output  1  store element accepted when st_valid&&st_ready
st_data  input  32  store element (low SEW bits used)
mem_valid  output  1  memory request
mem_ready  input  1  responder acknowledge, rdata valid same cycle
mem_addr  output  ADDR_W  word-aligned address (addr & ~3)
mem_wdata  output  32  write data, element replicated into its lanes
mem_wstrb  output  4  byte enables, 0 for reads
mem_rdata  input  32  read data
done  output  1  one-cycle pulse at command end
err  output  1  valid with done, misaligned or illegal SEW

Behaviour:
- Reset (synchronous, resetn=0): state IDLE. mem_valid, ld_valid, st_ready, done and err are 0; mem_wstrb is 0; cmd_ready is 1 the cycle after reset releases. Reset during any state aborts immediately with no done pulse.
- States: IDLE, CHECK, LREQ, SWAIT, SREQ, GAP, FIN.
- IDLE: on cmd_valid&&cmd_ready, latch all command fields; set addr=cmd_base, idx=0; go to CHECK.
- CHECK:
  - If idx==vl, go to FIN with err=0.
  - If SEW==3, or (SEW==1 && addr[0]), or (SEW==2 && addr[1:0]!=0), go to FIN with err=1. No memory access is made for that element; elements already completed stand.
  - Otherwise go to LREQ (load) or SWAIT (store).
- LREQ: mem_valid=1, wstrb=0; address held stable until mem_ready.
  - On mem_ready, extract the lane at addr[1:0] from mem_rdata and zero-extend it.
  - Next cycle: ld_valid=1 with ld_data and ld_idx=idx.
  - Then idx+1, addr=addr+stride (mod 2^ADDR_W, so a negative stride wraps), go to GAP.
- SWAIT: st_ready=1. On a st_valid handshake, latch the data and go to SREQ.
- SREQ: mem_valid=1.
  - wdata is the element replicated: SEW8 ×4, SEW16 ×2, SEW32 ×1.
  - wstrb by SEW: SEW8 → 1<<addr[1:0]; SEW16 → 0011 or 1100 by addr[1]; SEW32 → 1111.
  - On mem_ready: idx+1, addr+=stride, go to GAP.
- GAP: mem_valid=0 for exactly one cycle, because the responder ignores valid in the cycle after ready. Then go to CHECK.
- FIN: done=1 (err as set) for one cycle, then IDLE.
- mem_valid drops in the cycle after mem_ready is sampled. Back-to-back requests are always separated by at least one idle cycle.
- vl=0: done pulses 2 cycles after accept (CHECK, FIN). No mem_valid, ld_valid or st_ready.
- Latency, load with 1-cycle responder: accept → mem_valid at +2; ld_valid 1 cycle after mem_ready. Each element takes 4 cycles (CHECK, LREQ, ready cycle, GAP).
- Elements complete strictly in index order. Only one request is outstanding at a time.

Test Plan:
- Load SEW8, base 400, stride 3, vl 3; memory words at 400 = 0x04030201, 404 = 0x08070605 → ld_data 0x01, 0x04, 0x07 at idx 0, 1, 2; mem_addr 400, 400, 404; done=1, err=0.
- Load SEW16, base 412, stride 4, vl 2; word 412 = 0x00080007, word 416 = 0x000a0009 → ld_data 0x0007, 0x0009.
- Store SEW8, base 800, stride 1, vl 4, st_data 0xAA, 0xBB, 0xCC, 0xDD → four writes to 800 with wstrb 0001, 0010, 0100, 1000; word 800 reads back 0xDDCCBBAA; done=1, err=0.
- Negative stride, load SEW8, base 406, stride −3, vl 3 → ld_data 0x07, 0x04, 0x01.
- Error and empty cases:
  - SEW32, base 401 → err=1 with done, zero mem_valid cycles.
  - vl=0 → done at accept+2, err=0, no memory traffic.
  - SEW=3 → err=1.
- Reset mid-operation: assert resetn=0 during LREQ of element 1 → next cycle mem_valid=0, cmd_ready=1, no done pulse; a subsequent command then completes normally.

Source files
------------

// File: rtl/vec_strided_lsu_if.sv
`default_nettype none
// ============================================================================
// Module : vec_strided_lsu_if
// Native valid/ready memory port between the strided LSU and the memory.
// Rev    : 1.0
// ============================================================================
interface vec_strided_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [31:0]       rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface
`default_nettype wire

// File: rtl/vec_strided_lsu.sv
`default_nettype none
// ============================================================================
// Module : vec_strided_lsu
// Strided vector load/store engine: one memory access per element, in order.
// Rev    : 1.0
// ============================================================================
module vec_strided_lsu #(
    parameter int VL_W   = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_store,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [31:0]       cmd_stride,
    input  logic [VL_W-1:0]   cmd_vl,
    input  logic [1:0]        cmd_sew,

    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [VL_W-1:0]   ld_idx,

    input  logic              st_valid,
    output logic              st_ready,
    input  logic [31:0]       st_data,

    output logic              done,
    output logic              err,

    vec_strided_lsu_if.master mem
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        LREQ  = 3'd2,
        SWAIT = 3'd3,
        SREQ  = 3'd4,
        GAP   = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_store;
    logic [1:0]        r_sew;
    logic [31:0]       r_stride;
    logic [VL_W-1:0]   r_vl;
    logic [VL_W-1:0]   r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_st_data;
    logic              r_err;

    logic              r_ld_valid;
    logic [31:0]       r_ld_data;
    logic [VL_W-1:0]   r_ld_idx;

    logic              w_accept;
    logic              w_last;
    logic              w_bad;
    logic [ADDR_W-1:0] w_stride_ext;
    logic [ADDR_W-1:0] w_addr_next;
    logic [31:0]       w_shift;
    logic [31:0]       w_lane;
    logic [31:0]       w_wdata;
    logic [3:0]        w_strb;

    assign w_accept     = cmd_valid && (r_state == IDLE);
    assign w_last       = (r_idx == r_vl);
    assign w_bad        = (r_sew == 2'd3)
                       || ((r_sew == 2'd1) && r_addr[0])
                       || ((r_sew == 2'd2) && (r_addr[1:0] != 2'b00));

    // Stride is signed; the address wraps modulo 2^ADDR_W.
    assign w_stride_ext = ADDR_W'($signed(r_stride));
    assign w_addr_next  = r_addr + w_stride_ext;

    // Alignment is guaranteed before any access, so the shift lands the lane at bit 0.
    assign w_shift      = mem.rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_lane  = w_shift;
        w_wdata = r_st_data;
        w_strb  = 4'b1111;
        case (r_sew)
            2'd0: begin
                w_lane  = {24'd0, w_shift[7:0]};
                w_wdata = {4{r_st_data[7:0]}};
                w_strb  = 4'b0001 << r_addr[1:0];
            end
            2'd1: begin
                w_lane  = {16'd0, w_shift[15:0]};
                w_wdata = {2{r_st_data[15:0]}};
                w_strb  = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign mem.addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem.wdata = w_wdata;
    assign mem.wstrb = (r_state == SREQ) ? w_strb : 4'b0000;

    assign ld_valid  = r_ld_valid;
    assign ld_data   = r_ld_data;
    assign ld_idx    = r_ld_idx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        st_ready  = 1'b0;
        mem.valid = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_last || w_bad) begin
                    w_next = FIN;
                end else if (r_store) begin
                    w_next = SWAIT;
                end else begin
                    w_next = LREQ;
                end
            end
            LREQ: begin
                mem.valid = 1'b1;
                if (mem.ready) begin
                    w_next = GAP;
                end
            end
            SWAIT: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    w_next = SREQ;
                end
            end
            SREQ: begin
                mem.valid = 1'b1;
                if (mem.ready) begin
                    w_next = GAP;
                end
            end
            // The responder ignores valid in the cycle after ready.
            GAP: begin
                w_next = CHECK;
            end
            FIN: begin
                done   = 1'b1;
                err    = r_err;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_store    <= 1'b0;
            r_sew      <= 2'd0;
            r_stride   <= 32'd0;
            r_vl       <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_st_data  <= 32'd0;
            r_err      <= 1'b0;
            r_ld_valid <= 1'b0;
            r_ld_data  <= 32'd0;
            r_ld_idx   <= '0;
        end else begin
            r_ld_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_store  <= cmd_store;
                        r_sew    <= cmd_sew;
                        r_stride <= cmd_stride;
                        r_vl     <= cmd_vl;
                        r_addr   <= cmd_base;
                        r_idx    <= '0;
                        r_err    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!w_last && w_bad) begin
                        r_err <= 1'b1;
                    end
                end
                LREQ: begin
                    if (mem.ready) begin
                        r_ld_valid <= 1'b1;
                        r_ld_data  <= w_lane;
                        r_ld_idx   <= r_idx;
                        r_idx      <= r_idx + VL_W'(1);
                        r_addr     <= w_addr_next;
                    end
                end
                SWAIT: begin
                    if (st_valid) begin
                        r_st_data <= st_data;
                    end
                end
                SREQ: begin
                    if (mem.ready) begin
                        r_idx  <= r_idx + VL_W'(1);
                        r_addr <= w_addr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_strided_lsu.sv
`default_nettype none
// Directed bench: byte-level memory responder plus a reference model that derives each
// element's address, lane value, write data and strobes from base + i*stride.
module tb_vec_strided_lsu;
    localparam int VL_W   = 8;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_store = 1'b0;
    logic [31:0] cmd_base = 32'd0;
    logic [31:0] cmd_stride = 32'd0;
    logic [7:0]  cmd_vl = 8'd0;
    logic [1:0]  cmd_sew = 2'd0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [7:0]  ld_idx;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_data = 32'd0;
    logic        done;
    logic        err;

    vec_strided_lsu_if #(.ADDR_W(ADDR_W)) mem_if ();

    vec_strided_lsu #(.VL_W(VL_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_vl(cmd_vl), .cmd_sew(cmd_sew),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_idx(ld_idx),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .done(done), .err(err),
        .mem(mem_if)
    );

    typedef struct { logic [31:0] data; logic [7:0] idx; } ld_t;
    typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } req_t;

    int n_pass = 0;
    int n_total = 0;
    bit [7:0] mem_b [int unsigned];
    bit [7:0] ref_b [int unsigned];
    int lat = 0;
    ld_t  exp_ld[$];
    req_t exp_req[$];
    bit   exp_err = 1'b0;
    bit   exp_done_pending = 1'b0;
    logic [31:0] ld_log[$];
    logic [31:0] addr_log[$];
    logic [31:0] strb_log[$];
    int mv_cycles = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic bit [7:0] byte_of(input bit is_ref, input logic [31:0] a);
        if (is_ref) return ref_b.exists(a) ? ref_b[a] : 8'h00;
        return mem_b.exists(a) ? mem_b[a] : 8'h00;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            mem_b[a + b] = w[8*b +: 8];
            ref_b[a + b] = w[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] peek(input logic [31:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = byte_of(1'b0, a + b);
        return w;
    endfunction

    // Reference model: expected loads, requests and err for one command.
    task automatic model_cmd(input bit store, input logic [31:0] base, input logic [31:0] stride,
                             input int vl, input logic [1:0] sew, input logic [31:0] sd[$]);
        int sz;
        int off;
        logic [31:0] a;
        logic [31:0] v;
        req_t r;
        ld_t  l;
        exp_err = 1'b0;
        exp_done_pending = 1'b1;
        sz = (sew == 2'd0) ? 1 : (sew == 2'd1) ? 2 : 4;
        for (int i = 0; i < vl; i++) begin
            a = base + stride * 32'(i);
            if (sew == 2'd3 || (a % sz) != 0) begin
                exp_err = 1'b1;
                break;
            end
            off = int'(a % 4);
            r.addr = a - (a % 4);
            r.strb = 4'b0000;
            r.wdata = 32'd0;
            if (!store) begin
                v = 32'd0;
                for (int k = 0; k < sz; k++) v[8*k +: 8] = byte_of(1'b1, a + k);
                l.data = v;
                l.idx = 8'(i);
                exp_ld.push_back(l);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    r.wdata[8*b +: 8] = sd[i][8*(b % sz) +: 8];
                    if (b >= off && b < off + sz) begin
                        r.strb[b] = 1'b1;
                        ref_b[r.addr + b] = sd[i][8*(b - off) +: 8];
                    end
                end
            end
            exp_req.push_back(r);
        end
    endtask

    // Memory responder: ready after lat waiting cycles, never in the cycle after ready.
    initial begin
        logic [31:0] wa;
        logic [31:0] rd;
        int rcnt;
        rcnt = 0;
        mem_if.ready = 1'b0;
        mem_if.rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!resetn || mem_if.ready || !mem_if.valid) begin
                mem_if.ready = 1'b0;
                rcnt = 0;
            end else if (rcnt < lat) begin
                rcnt++;
            end else begin
                mem_if.ready = 1'b1;
                wa = {mem_if.addr[31:2], 2'b00};
                for (int b = 0; b < 4; b++) begin
                    rd[8*b +: 8] = byte_of(1'b0, wa + b);
                    if (mem_if.wstrb[b]) mem_b[wa + b] = mem_if.wdata[8*b +: 8];
                end
                mem_if.rdata = rd;
            end
        end
    end

    // Compare process: checks every cycle against the model's queues.
    initial begin
        ld_t  e;
        req_t r;
        bit hs;
        bit prev_hs;
        bit prev_rd;
        prev_hs = 1'b0;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                prev_hs = 1'b0;
                prev_rd = 1'b0;
            end else begin
                if (mem_if.valid) mv_cycles++;
                if (prev_hs) chk("gap_after_ready", mem_if.valid, 1'b0);
                if (prev_rd) chk("ld_latency", ld_valid, 1'b1);
                if (ld_valid) begin
                    chk("ld_expected", exp_ld.size() > 0, 1'b1);
                    if (exp_ld.size() > 0) begin
                        e = exp_ld.pop_front();
                        chk("ld_data", ld_data, e.data);
                        chk("ld_idx", ld_idx, e.idx);
                    end
                    ld_log.push_back(ld_data);
                end
                hs = mem_if.valid && mem_if.ready;
                if (hs) begin
                    chk("req_expected", exp_req.size() > 0, 1'b1);
                    if (exp_req.size() > 0) begin
                        r = exp_req.pop_front();
                        chk("mem_addr", mem_if.addr, r.addr);
                        chk("mem_wstrb", mem_if.wstrb, r.strb);
                        if (r.strb != 4'b0000) chk("mem_wdata", mem_if.wdata, r.wdata);
                    end
                    addr_log.push_back(mem_if.addr);
                    strb_log.push_back({28'd0, mem_if.wstrb});
                end
                prev_hs = hs;
                prev_rd = hs && (mem_if.wstrb == 4'b0000);
                if (done) begin
                    done_cnt++;
                    chk("done_expected", exp_done_pending, 1'b1);
                    chk("err", err, exp_err);
                    chk("loads_outstanding", exp_ld.size(), 0);
                    chk("reqs_outstanding", exp_req.size(), 0);
                    exp_done_pending = 1'b0;
                end
            end
        end
    end

    task automatic run_cmd(input bit store, input logic [31:0] base, input logic [31:0] stride,
                           input int vl, input logic [1:0] sew, input logic [31:0] sd[$],
                           output int acc, output int dn, output int fmv, output logic e);
        int n;
        int si;
        bit fin;
        model_cmd(store, base, stride, vl, sew, sd);
        ld_log.delete();
        addr_log.delete();
        strb_log.delete();
        @(negedge clk);
        mv_cycles = 0;
        cmd_valid = 1'b1;
        cmd_store = store;
        cmd_base = base;
        cmd_stride = stride;
        cmd_vl = 8'(vl);
        cmd_sew = sew;
        acc = -1; dn = -1; fmv = -1; e = 1'b0;
        n = 0; si = 0; fin = 1'b0;
        while (!fin && n < 2000) begin
            #1;
            if (cmd_valid && cmd_ready) acc = n;
            if (mem_if.valid && fmv < 0) fmv = n;
            if (st_valid && st_ready) si++;
            if (done) begin
                fin = 1'b1;
                dn = n;
                e = err;
            end
            @(negedge clk);
            n++;
            if (acc >= 0) cmd_valid = 1'b0;
            st_valid = (acc >= 0) && (si < sd.size()) && !fin;
            st_data = st_valid ? sd[si] : 32'd0;
        end
        cmd_valid = 1'b0;
        st_valid = 1'b0;
        chk("done_seen", fin, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sdq[$];
        int acc, dn, fmv, n, dc0;
        logic e;
        bit hit, accd;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_valid", mem_if.valid, 1'b0);
        chk("rst_ld_valid", ld_valid, 1'b0);
        chk("rst_st_ready", st_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wstrb", mem_if.wstrb, 4'b0000);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        poke(32'd400, 32'h0403_0201);
        poke(32'd404, 32'h0807_0605);
        poke(32'd412, 32'h0008_0007);
        poke(32'd416, 32'h000a_0009);
        poke(32'd500, 32'h4433_2211);
        sdq.delete();

        // Load SEW8, stride 3
        run_cmd(1'b0, 32'd400, 32'd3, 3, 2'd0, sdq, acc, dn, fmv, e);
        chk("t1_d0", qget(ld_log, 0), 32'h01);
        chk("t1_d1", qget(ld_log, 1), 32'h04);
        chk("t1_d2", qget(ld_log, 2), 32'h07);
        chk("t1_a0", qget(addr_log, 0), 32'd400);
        chk("t1_a1", qget(addr_log, 1), 32'd400);
        chk("t1_a2", qget(addr_log, 2), 32'd404);
        chk("t1_err", e, 1'b0);
        chk("t1_first_valid", fmv, acc + 2);

        // Load SEW16, stride 4
        run_cmd(1'b0, 32'd412, 32'd4, 2, 2'd1, sdq, acc, dn, fmv, e);
        chk("t2_d0", qget(ld_log, 0), 32'h0007);
        chk("t2_d1", qget(ld_log, 1), 32'h0009);

        // Store SEW8, stride 1
        sdq = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
        run_cmd(1'b1, 32'd800, 32'd1, 4, 2'd0, sdq, acc, dn, fmv, e);
        chk("t3_s0", qget(strb_log, 0), 32'b0001);
        chk("t3_s1", qget(strb_log, 1), 32'b0010);
        chk("t3_s2", qget(strb_log, 2), 32'b0100);
        chk("t3_s3", qget(strb_log, 3), 32'b1000);
        chk("t3_word", peek(32'd800), 32'hDDCC_BBAA);
        chk("t3_err", e, 1'b0);
        sdq.delete();

        // Negative stride
        run_cmd(1'b0, 32'd406, 32'hFFFF_FFFD, 3, 2'd0, sdq, acc, dn, fmv, e);
        chk("t4_d0", qget(ld_log, 0), 32'h07);
        chk("t4_d1", qget(ld_log, 1), 32'h04);
        chk("t4_d2", qget(ld_log, 2), 32'h01);

        // Misaligned SEW32
        run_cmd(1'b0, 32'd401, 32'd4, 2, 2'd2, sdq, acc, dn, fmv, e);
        chk("t5_err", e, 1'b1);
        chk("t5_no_mem", mv_cycles, 0);

        // vl = 0
        run_cmd(1'b0, 32'd400, 32'd4, 0, 2'd0, sdq, acc, dn, fmv, e);
        chk("t6_done_lat", dn, acc + 2);
        chk("t6_err", e, 1'b0);
        chk("t6_no_mem", mv_cycles, 0);

        // Illegal SEW
        run_cmd(1'b0, 32'd400, 32'd4, 2, 2'd3, sdq, acc, dn, fmv, e);
        chk("t7_err", e, 1'b1);
        chk("t7_no_mem", mv_cycles, 0);

        // Misalignment after one completed element
        run_cmd(1'b0, 32'd500, 32'd3, 3, 2'd1, sdq, acc, dn, fmv, e);
        chk("t8_err", e, 1'b1);
        chk("t8_count", ld_log.size(), 1);
        chk("t8_d0", qget(ld_log, 0), 32'h2211);

        // SEW16 store in the upper half, then SEW32 load back, slow responder
        lat = 2;
        sdq = '{32'hFFFF_1234, 32'h0000_5678};
        run_cmd(1'b1, 32'd902, 32'd4, 2, 2'd1, sdq, acc, dn, fmv, e);
        chk("t9_s0", qget(strb_log, 0), 32'b1100);
        chk("t9_s1", qget(strb_log, 1), 32'b1100);
        sdq.delete();
        run_cmd(1'b0, 32'd900, 32'd4, 2, 2'd2, sdq, acc, dn, fmv, e);
        chk("t9_d0", qget(ld_log, 0), 32'h1234_0000);
        chk("t9_d1", qget(ld_log, 1), 32'h5678_0000);

        // Reset during the request of element 1
        lat = 3;
        model_cmd(1'b0, 32'd400, 32'd1, 4, 2'd0, sdq);
        ld_log.delete();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_store = 1'b0;
        cmd_base = 32'd400;
        cmd_stride = 32'd1;
        cmd_vl = 8'd4;
        cmd_sew = 2'd0;
        n = 0; hit = 1'b0; accd = 1'b0;
        while (!hit && n < 200) begin
            #1;
            if (cmd_valid && cmd_ready) accd = 1'b1;
            if (ld_log.size() >= 1 && mem_if.valid) hit = 1'b1;
            else begin
                @(negedge clk);
                n++;
                if (accd) cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("t10_reached", hit, 1'b1);
        resetn = 1'b0;
        exp_ld.delete();
        exp_req.delete();
        exp_done_pending = 1'b0;
        dc0 = done_cnt;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("t10_mem_valid", mem_if.valid, 1'b0);
        chk("t10_cmd_ready", cmd_ready, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        chk("t10_no_done", done_cnt, dc0);
        lat = 0;
        run_cmd(1'b0, 32'd400, 32'd3, 3, 2'd0, sdq, acc, dn, fmv, e);
        chk("t10_after_d2", qget(ld_log, 2), 32'h07);
        chk("t10_after_err", e, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
